param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 13, giving the register width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 3, giving the address width.
REQ-003 The block SHALL provide parameter NUM_REGS, default 8, giving the implemented register count (2 <= NUM_REGS <= 2**ADDR_W).
REQ-004 The block SHALL provide parameter ZERO_R0, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-005 The block SHALL provide parameter BYPASS, default 1; when 1, same-cycle writes forward to reads.
REQ-006 Port: clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 Port: reset, input, 1 bit, asynchronous active-high reset.
REQ-008 Port: i_memWrite, input, 1 bit, write enable.
REQ-009 Port: i_memRead, input, 1 bit, read enable for both read ports.
REQ-010 Port: i_clear, input, 1 bit, single-cycle request to start a sequential clear of all registers.
REQ-011 Port: i_address1, input, ADDR_W bits, read port A address.
REQ-012 Port: i_address2, input, ADDR_W bits, read port B address.
REQ-013 Port: i_destReg, input, ADDR_W bits, write address.
REQ-014 Port: i_ALUresult, input, DATA_W bits, write data.
REQ-015 Port: o_dataA, output, DATA_W bits, registered read data for port A.
REQ-016 Port: o_dataB, output, DATA_W bits, registered read data for port B.
REQ-017 Port: o_busy, output, 1 bit, high while a clear sequence is in progress.
REQ-018 Port: o_addr_err, output, 1 bit, one-cycle pulse flagging an out-of-range address on an enabled access.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-020 In IDLE, i_clear=1 SHALL move the FSM to CLEAR, load a clear pointer with 0, and set o_busy=1 on the next edge.
REQ-021 In CLEAR, each cycle SHALL zero register[ptr] and increment ptr.
REQ-022 The FSM SHALL return to IDLE and drop o_busy on the edge that clears register NUM_REGS-1, so the sequence takes exactly NUM_REGS cycles.
REQ-023 In CLEAR, i_memWrite, i_memRead and i_clear SHALL be ignored, and o_dataA and o_dataB SHALL read 0.
REQ-024 In IDLE with i_memWrite=1 and i_destReg < NUM_REGS, i_ALUresult SHALL be written to register[i_destReg] at the edge, except when ZERO_R0=1 and i_destReg=0.
REQ-025 In IDLE with i_memRead=1, o_dataA and o_dataB SHALL update at the edge with register[i_address1] and register[i_address2] (1-cycle latency).
REQ-026 With i_memRead=0, o_dataA and o_dataB SHALL be loaded with 0 at the edge.
REQ-027 When read and write are simultaneous and the addresses match, BYPASS=1 SHALL return the new write data; BYPASS=0 SHALL return the old register contents.
REQ-028 Forwarding SHALL NOT apply to a suppressed write (R0 with ZERO_R0=1, or out of range).
REQ-029 An address >= NUM_REGS SHALL cause the write to be dropped and that read port to return 0.
REQ-030 Any such out-of-range address on an enabled access SHALL pulse o_addr_err high for one cycle, registered with the data.
REQ-031 Both read ports SHALL be able to read the same address in the same cycle, each returning identical data.
REQ-032 An i_clear request during CLEAR SHALL be ignored and SHALL NOT restart the sequence.

Reset
REQ-033 When reset=1, regardless of clk, all registers, o_dataA, o_dataB, o_busy, o_addr_err and the clear pointer SHALL immediately become 0, and the FSM SHALL enter IDLE.
REQ-034 A reset asserted mid-CLEAR SHALL abort the sequence, and the block SHALL be in IDLE at the first edge after reset is released.

Verification
REQ-035 Write 13'h1ABC to r3, then read r3 on A and r0 on B -> next cycle o_dataA=13'h1ABC, o_dataB=0.
REQ-036 Same cycle: write 13'h0055 to r5 and read r5 on A -> o_dataA=13'h0055 with BYPASS=1, old value 0 with BYPASS=0.
REQ-037 Write 13'h1FFF to r0 with ZERO_R0=1, then read r0 -> 0; with ZERO_R0=0 -> 13'h1FFF.
REQ-038 NUM_REGS=6: write to r7, then read r7 -> write dropped, o_dataA=0, o_addr_err pulses exactly one cycle.
REQ-039 Fill r1..r7, pulse i_clear, drive writes during busy -> o_busy high exactly 8 cycles, all registers read 0 afterwards, writes during busy lost.
REQ-040 Assert reset asynchronously at clear cycle 3 -> all outputs 0 immediately, IDLE after release, all registers read 0.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised register file: two registered read ports, one write port,
// optional same-cycle write forwarding and a sequential clear engine.
module param_register_file #(
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ZERO_R0  = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_memWrite,
  input  logic              i_memRead,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_address1,
  input  logic [ADDR_W-1:0] i_address2,
  input  logic [ADDR_W-1:0] i_destReg,
  input  logic [DATA_W-1:0] i_ALUresult,
  output logic [DATA_W-1:0] o_dataA,
  output logic [DATA_W-1:0] o_dataB,
  output logic              o_busy,
  output logic              o_addr_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              idle;
  logic              wr_in_range;
  logic              a1_in_range;
  logic              a2_in_range;
  logic              wr_en;
  logic              rd_en;
  logic              addr_err_d;
  logic [DATA_W-1:0] rd_a_d;
  logic [DATA_W-1:0] rd_b_d;

  // State and clear-pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a clear walks every register once, then returns to IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Access qualification; all host accesses are ignored while clearing
  always_comb begin
    idle        = (state_q == IDLE);
    wr_in_range = ({1'b0, i_destReg} < NUM_REGS_X);
    a1_in_range = ({1'b0, i_address1} < NUM_REGS_X);
    a2_in_range = ({1'b0, i_address2} < NUM_REGS_X);
    wr_en       = idle && i_memWrite && wr_in_range &&
                  !((ZERO_R0 != 0) && (i_destReg == '0));
    rd_en       = idle && i_memRead;
    addr_err_d  = idle && ((i_memWrite && !wr_in_range) ||
                           (i_memRead && (!a1_in_range || !a2_in_range)));
  end

  // Read muxes with optional forwarding of an accepted write
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (i_address1 == ADDR_W'(i)) rd_a_d = regs_q[i];
      if (i_address2 == ADDR_W'(i)) rd_b_d = regs_q[i];
    end
    if ((BYPASS != 0) && wr_en && (i_address1 == i_destReg)) rd_a_d = i_ALUresult;
    if ((BYPASS != 0) && wr_en && (i_address2 == i_destReg)) rd_b_d = i_ALUresult;
    if (!rd_en || !a1_in_range) rd_a_d = '0;
    if (!rd_en || !a2_in_range) rd_b_d = '0;
  end

  // Register array: clear engine has priority over host writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if ((state_q == CLEAR) && (ptr_q == PTR_W'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_en && (i_destReg == ADDR_W'(i))) begin
          regs_q[i] <= i_ALUresult;
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_dataA    <= '0;
      o_dataB    <= '0;
      o_busy     <= 1'b0;
      o_addr_err <= 1'b0;
    end else begin
      o_dataA    <= rd_a_d;
      o_dataB    <= rd_b_d;
      o_busy     <= (state_d == CLEAR);
      o_addr_err <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: a default instance and a
// NUM_REGS=6 / BYPASS=0 / ZERO_R0=0 instance share one stimulus stream.
module tb_param_register_file;

  localparam int unsigned DW = 13;
  localparam int unsigned AW = 3;

  localparam int A0 = 0, B0 = 1, ER0 = 2, BY0 = 3;
  localparam int A1 = 4, B1 = 5, ER1 = 6, BY1 = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_write = 1'b0;
  logic          mem_read = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [AW-1:0] addr2 = '0;
  logic [AW-1:0] dest = '0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] data_a0, data_b0, data_a1, data_b1;
  logic          busy0, err0, busy1, err1;

  typedef struct {
    string         tag;
    int            sel;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  param_register_file dut0 (
    .clk(clk), .reset(reset), .i_memWrite(mem_write), .i_memRead(mem_read),
    .i_clear(clear), .i_address1(addr1), .i_address2(addr2), .i_destReg(dest),
    .i_ALUresult(wdata), .o_dataA(data_a0), .o_dataB(data_b0),
    .o_busy(busy0), .o_addr_err(err0)
  );

  param_register_file #(.NUM_REGS(6), .BYPASS(0), .ZERO_R0(0)) dut1 (
    .clk(clk), .reset(reset), .i_memWrite(mem_write), .i_memRead(mem_read),
    .i_clear(clear), .i_address1(addr1), .i_address2(addr2), .i_destReg(dest),
    .i_ALUresult(wdata), .o_dataA(data_a1), .o_dataB(data_b1),
    .o_busy(busy1), .o_addr_err(err1)
  );

  function automatic logic [DW-1:0] obs(int sel);
    case (sel)
      A0:      return data_a0;
      B0:      return data_b0;
      ER0:     return DW'(err0);
      BY0:     return DW'(busy0);
      A1:      return data_a1;
      B1:      return data_b1;
      ER1:     return DW'(err1);
      default: return DW'(busy1);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic flush();
    exp_t          e;
    logic [DW-1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    flush();
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] d, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] x, input logic [AW-1:0] y,
                       input logic clr);
    mem_write = we;
    dest      = d;
    wdata     = wd;
    mem_read  = re;
    addr1     = x;
    addr2     = y;
    clear     = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    expect_val("rst_a0", A0, '0);
    expect_val("rst_b0", B0, '0);
    expect_val("rst_busy0", BY0, '0);
    expect_val("rst_err0", ER0, '0);
    expect_val("rst_busy1", BY1, '0);
    flush();
    #10 reset = 1'b0;

    // Write r3, then read r3 / r0
    drive(1'b1, 3'd3, 13'h1ABC, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_val("wr_err0", ER0, '0);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd3, 3'd0, 1'b0);
    expect_val("rd_r3_a0", A0, 13'h1ABC);
    expect_val("rd_r0_b0", B0, 13'h0000);
    expect_val("rd_r3_a1", A1, 13'h1ABC);
    expect_val("rd_r0_b1", B1, 13'h0000);
    step();

    // Same-cycle write/read of r5 on both ports
    drive(1'b1, 3'd5, 13'h0055, 1'b1, 3'd5, 3'd5, 1'b0);
    expect_val("byp_a0", A0, 13'h0055);
    expect_val("byp_b0", B0, 13'h0055);
    expect_val("nobyp_a1", A1, 13'h0000);
    expect_val("nobyp_b1", B1, 13'h0000);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd5, 3'd5, 1'b0);
    expect_val("r5_a0", A0, 13'h0055);
    expect_val("r5_a1", A1, 13'h0055);
    step();

    // R0 writes: hardwired zero vs ordinary register
    drive(1'b1, 3'd0, 13'h1FFF, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_val("noread_a0", A0, 13'h0000);
    expect_val("noread_a1", A1, 13'h0000);
    step();
    drive(1'b1, 3'd0, 13'h0AAA, 1'b1, 3'd0, 3'd0, 1'b0);
    expect_val("r0_zero_nofwd_a0", A0, 13'h0000);
    expect_val("r0_old_a1", A1, 13'h1FFF);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd0, 3'd0, 1'b0);
    expect_val("r0_zero_a0", A0, 13'h0000);
    expect_val("r0_new_a1", A1, 13'h0AAA);
    step();

    // r7: in range for dut0, out of range for dut1
    drive(1'b1, 3'd7, 13'h0123, 1'b1, 3'd7, 3'd3, 1'b0);
    expect_val("r7_fwd_a0", A0, 13'h0123);
    expect_val("r3_b0", B0, 13'h1ABC);
    expect_val("r7_err0", ER0, '0);
    expect_val("oor_a1", A1, 13'h0000);
    expect_val("r3_b1", B1, 13'h1ABC);
    expect_val("oor_err1", ER1, 13'h1);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_val("oor_err1_drop", ER1, '0);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd7, 3'd7, 1'b0);
    expect_val("r7_a0", A0, 13'h0123);
    expect_val("oor_rd_a1", A1, 13'h0000);
    expect_val("oor_rd_err1", ER1, 13'h1);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_val("oor_rd_err1_drop", ER1, '0);
    step();

    // Fill r1..r7 and spot-check
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, AW'(i), DW'(i * 'h111), 1'b0, 3'd0, 3'd0, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd6, 3'd1, 1'b0);
    expect_val("fill_r6_a0", A0, 13'h0666);
    expect_val("fill_r1_b0", B0, 13'h0111);
    step();

    // Clear sequence with host traffic during busy
    drive(1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    expect_val("clr_busy0_k0", BY0, 13'h1);
    expect_val("clr_busy1_k0", BY1, 13'h1);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 3'd2, 13'h1EEE, 1'b1, 3'd2, 3'd3, k == 4);
      expect_val($sformatf("clr_busy0_k%0d", k), BY0, DW'(k < 8));
      expect_val($sformatf("clr_busy1_k%0d", k), BY1, DW'(k < 6));
      expect_val($sformatf("clr_a0_k%0d", k), A0, 13'h0000);
      expect_val($sformatf("clr_b0_k%0d", k), B0, 13'h0000);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 13'h0, 1'b1, AW'(i), AW'(7 - i), 1'b0);
      expect_val($sformatf("post_clr_a0_r%0d", i), A0, 13'h0000);
      expect_val($sformatf("post_clr_b0_r%0d", 7 - i), B0, 13'h0000);
      expect_val("post_clr_busy0", BY0, '0);
      step();
    end

    // Reset aborting a clear at cycle 3
    drive(1'b1, 3'd4, 13'h0444, 1'b0, 3'd0, 3'd0, 1'b0);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b1, 3'd4, 3'd4, 1'b0);
    expect_val("pre_rst_r4_a0", A0, 13'h0444);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    drive(1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 3'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      expect_val($sformatf("pre_rst_busy0_k%0d", k), BY0, 13'h1);
      step();
    end
    reset = 1'b1;
    #1;
    expect_val("async_rst_busy0", BY0, '0);
    expect_val("async_rst_busy1", BY1, '0);
    expect_val("async_rst_a0", A0, '0);
    expect_val("async_rst_err0", ER0, '0);
    flush();
    @(negedge clk);
    reset = 1'b0;
    expect_val("post_rst_idle0", BY0, '0);
    expect_val("post_rst_idle1", BY1, '0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 13'h0, 1'b1, AW'(i), AW'(i), 1'b0);
      expect_val($sformatf("post_rst_a0_r%0d", i), A0, 13'h0000);
      expect_val("post_rst_busy0", BY0, '0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
